// File: rtl/pixel_sort_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pixel_sort_pkg
//  Description : Shared constants and the Batcher odd-even merge wiring table
//                for the 8-input ascending pixel sorter.
//  Revision    : 1.0  initial release
// ============================================================================
package pixel_sort_pkg;

    // Default pixel width, element count and comparator layer count
    localparam int c_DATA_W_DEF   = 16;
    localparam int c_N_ELEM       = 8;
    localparam int c_N_LAYERS     = 6;
    // Registered comparator stages, two comparator layers each
    localparam int c_N_CMP_STAGES = 3;

    // Sample-to-result latency in clk cycles
`ifdef PIXEL_SORT_IN_REG_EN
    localparam int c_PIPE_DEPTH   = 4;
`else
    localparam int c_PIPE_DEPTH   = 3;
`endif

    // Partner lane of 'lane' in comparator 'layer' of the 8-element Batcher
    // odd-even merge network. Returns 'lane' itself when the lane passes
    // through the layer untouched. The smaller index of a pair receives min.
    function automatic int cmp_partner(input int layer, input int lane);
        int p;
        p = lane;
        if (layer < c_N_LAYERS) begin
            case (layer)
                0: p = lane ^ 1;
                1: p = lane ^ 2;
                2: begin
                    if (lane == 1 || lane == 5)      p = lane + 1;
                    else if (lane == 2 || lane == 6) p = lane - 1;
                end
                3: p = lane ^ 4;
                4: begin
                    if (lane == 2 || lane == 3)      p = lane + 2;
                    else if (lane == 4 || lane == 5) p = lane - 2;
                end
                5: begin
                    if (lane == 1 || lane == 3 || lane == 5)      p = lane + 1;
                    else if (lane == 2 || lane == 4 || lane == 6) p = lane - 1;
                end
                default: p = lane;
            endcase
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_cmp_swap.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pixel_cmp_swap
//  Description : Combinational compare-exchange. lo = min(a,b), hi = max(a,b);
//                equal inputs pass straight through unchanged.
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_cmp_swap #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);

    logic w_swap;

    // Swap only on strict inequality so equal values keep their lanes
    always_comb begin
        w_swap = (b < a);
        lo     = w_swap ? b : a;
        hi     = w_swap ? a : b;
    end

endmodule
`default_nettype wire

// File: rtl/pixel_sort_asc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pixel_sort_asc
//  Description : Pipelined 8-input ascending sorter built from a 19-element,
//                6-layer Batcher odd-even merge network. Three registered
//                stages of two layers each feed a result register that only
//                loads on valid data. Throughput one set per cycle.
//  Options     : PIXEL_SORT_IN_REG_EN - adds an input register in front of
//                layer 1 (latency 4 instead of 3).
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_sort_asc
    import pixel_sort_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] Pixel_in1,
    input  logic [DATA_W-1:0] Pixel_in2,
    input  logic [DATA_W-1:0] Pixel_in3,
    input  logic [DATA_W-1:0] Pixel_in4,
    input  logic [DATA_W-1:0] Pixel_in5,
    input  logic [DATA_W-1:0] Pixel_in6,
    input  logic [DATA_W-1:0] Pixel_in7,
    input  logic [DATA_W-1:0] Pixel_in8,
    output logic [DATA_W-1:0] Pixel_out1,
    output logic [DATA_W-1:0] Pixel_out2,
    output logic [DATA_W-1:0] Pixel_out3,
    output logic [DATA_W-1:0] Pixel_out4,
    output logic [DATA_W-1:0] Pixel_out5,
    output logic [DATA_W-1:0] Pixel_out6,
    output logic [DATA_W-1:0] Pixel_out7,
    output logic [DATA_W-1:0] Pixel_out8,
    output logic              valid_out
);

    // Valid chain: optional input stage, three comparator stages, result.
    // The newest bit sits at index 0, valid_out is the top bit.
    localparam int c_VLD_LEN = c_PIPE_DEPTH + 1;
    localparam int c_V_S1    = c_VLD_LEN - c_N_CMP_STAGES - 1;
    localparam int c_V_S2    = c_V_S1 + 1;
    localparam int c_V_S3    = c_V_S1 + 2;

    logic [c_VLD_LEN-1:0] vld_q;

    logic [DATA_W-1:0] w_pix_in [c_N_ELEM];
    logic [DATA_W-1:0] w_src    [c_N_ELEM];
    logic              w_src_vld;

    logic [DATA_W-1:0] lay1_d [c_N_ELEM];
    logic [DATA_W-1:0] lay2_d [c_N_ELEM];
    logic [DATA_W-1:0] lay3_d [c_N_ELEM];
    logic [DATA_W-1:0] lay4_d [c_N_ELEM];
    logic [DATA_W-1:0] lay5_d [c_N_ELEM];
    logic [DATA_W-1:0] lay6_d [c_N_ELEM];

    logic [DATA_W-1:0] s1_q  [c_N_ELEM];
    logic [DATA_W-1:0] s2_q  [c_N_ELEM];
    logic [DATA_W-1:0] s3_q  [c_N_ELEM];
    logic [DATA_W-1:0] out_q [c_N_ELEM];

    assign w_pix_in[0] = Pixel_in1;
    assign w_pix_in[1] = Pixel_in2;
    assign w_pix_in[2] = Pixel_in3;
    assign w_pix_in[3] = Pixel_in4;
    assign w_pix_in[4] = Pixel_in5;
    assign w_pix_in[5] = Pixel_in6;
    assign w_pix_in[6] = Pixel_in7;
    assign w_pix_in[7] = Pixel_in8;

`ifdef PIXEL_SORT_IN_REG_EN
    logic [DATA_W-1:0] in_q [c_N_ELEM];

    // Input register: capture the pixel set only when it is qualified
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_N_ELEM; i++) in_q[i] <= '0;
        end else if (enable) begin
            for (int i = 0; i < c_N_ELEM; i++) in_q[i] <= w_pix_in[i];
        end
    end

    assign w_src     = in_q;
    assign w_src_vld = vld_q[0];
`else
    assign w_src     = w_pix_in;
    assign w_src_vld = enable;
`endif

    // Comparator layers 1..6; the lower lane of each pair owns the instance
    for (genvar k = 0; k < c_N_ELEM; k++) begin : g_lay1
        if (cmp_partner(0, k) == k) begin : g_pass
            assign lay1_d[k] = w_src[k];
        end else if (cmp_partner(0, k) > k) begin : g_cmp
            pixel_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
                .a (w_src[k]),  .b (w_src[cmp_partner(0, k)]),
                .lo(lay1_d[k]), .hi(lay1_d[cmp_partner(0, k)])
            );
        end
    end

    for (genvar k = 0; k < c_N_ELEM; k++) begin : g_lay2
        if (cmp_partner(1, k) == k) begin : g_pass
            assign lay2_d[k] = lay1_d[k];
        end else if (cmp_partner(1, k) > k) begin : g_cmp
            pixel_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
                .a (lay1_d[k]), .b (lay1_d[cmp_partner(1, k)]),
                .lo(lay2_d[k]), .hi(lay2_d[cmp_partner(1, k)])
            );
        end
    end

    for (genvar k = 0; k < c_N_ELEM; k++) begin : g_lay3
        if (cmp_partner(2, k) == k) begin : g_pass
            assign lay3_d[k] = s1_q[k];
        end else if (cmp_partner(2, k) > k) begin : g_cmp
            pixel_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
                .a (s1_q[k]),   .b (s1_q[cmp_partner(2, k)]),
                .lo(lay3_d[k]), .hi(lay3_d[cmp_partner(2, k)])
            );
        end
    end

    for (genvar k = 0; k < c_N_ELEM; k++) begin : g_lay4
        if (cmp_partner(3, k) == k) begin : g_pass
            assign lay4_d[k] = lay3_d[k];
        end else if (cmp_partner(3, k) > k) begin : g_cmp
            pixel_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
                .a (lay3_d[k]), .b (lay3_d[cmp_partner(3, k)]),
                .lo(lay4_d[k]), .hi(lay4_d[cmp_partner(3, k)])
            );
        end
    end

    for (genvar k = 0; k < c_N_ELEM; k++) begin : g_lay5
        if (cmp_partner(4, k) == k) begin : g_pass
            assign lay5_d[k] = s2_q[k];
        end else if (cmp_partner(4, k) > k) begin : g_cmp
            pixel_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
                .a (s2_q[k]),   .b (s2_q[cmp_partner(4, k)]),
                .lo(lay5_d[k]), .hi(lay5_d[cmp_partner(4, k)])
            );
        end
    end

    for (genvar k = 0; k < c_N_ELEM; k++) begin : g_lay6
        if (cmp_partner(5, k) == k) begin : g_pass
            assign lay6_d[k] = lay5_d[k];
        end else if (cmp_partner(5, k) > k) begin : g_cmp
            pixel_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
                .a (lay5_d[k]), .b (lay5_d[cmp_partner(5, k)]),
                .lo(lay6_d[k]), .hi(lay6_d[cmp_partner(5, k)])
            );
        end
    end

    // Valid chain shifts every cycle; enable enters at the bottom
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[c_VLD_LEN-2:0], enable};
        end
    end

    // Comparator stage registers load only alongside a valid set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_N_ELEM; i++) begin
                s1_q[i] <= '0;
                s2_q[i] <= '0;
                s3_q[i] <= '0;
            end
        end else begin
            if (w_src_vld) begin
                for (int i = 0; i < c_N_ELEM; i++) s1_q[i] <= lay2_d[i];
            end
            if (vld_q[c_V_S1]) begin
                for (int i = 0; i < c_N_ELEM; i++) s2_q[i] <= lay4_d[i];
            end
            if (vld_q[c_V_S2]) begin
                for (int i = 0; i < c_N_ELEM; i++) s3_q[i] <= lay6_d[i];
            end
        end
    end

    // Result register holds the last sorted set between valid pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_N_ELEM; i++) out_q[i] <= '0;
        end else if (vld_q[c_V_S3]) begin
            for (int i = 0; i < c_N_ELEM; i++) out_q[i] <= s3_q[i];
        end
    end

    assign Pixel_out1 = out_q[0];
    assign Pixel_out2 = out_q[1];
    assign Pixel_out3 = out_q[2];
    assign Pixel_out4 = out_q[3];
    assign Pixel_out5 = out_q[4];
    assign Pixel_out6 = out_q[5];
    assign Pixel_out7 = out_q[6];
    assign Pixel_out8 = out_q[7];
    assign valid_out  = vld_q[c_VLD_LEN-1];

endmodule
`default_nettype wire

// File: tb/tb_pixel_sort_asc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_sort_asc
//  Description : Directed self-checking bench for pixel_sort_asc.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_sort_asc;

`ifdef PIXEL_SORT_IN_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    // Expected outputs packed {Pixel_out8 .. Pixel_out1}
    localparam logic [127:0] EXP_A  = {16'd1037, 16'd456, 16'd345, 16'd345,
                                       16'd344,  16'd234, 16'd55,  16'd45};
    localparam logic [127:0] EXP_S  = {16'd700, 16'd600, 16'd500, 16'd400,
                                       16'd300, 16'd200, 16'd100, 16'd0};
    localparam logic [127:0] EXP_B1 = {16'd8, 16'd7, 16'd6, 16'd5,
                                       16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [127:0] EXP_B2 = {16'd65535, 16'd65535, 16'd2, 16'd2,
                                       16'd1,     16'd1,     16'd0, 16'd0};
    localparam logic [127:0] EXP_D  = {16'd4000, 16'd3000, 16'd2000, 16'd1000,
                                       16'd50,   16'd40,   16'd30,   16'd20};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] pin  [8];
    logic [15:0] pout [8];
    logic        valid_out;
    logic [127:0] got_v;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign got_v = {pout[7], pout[6], pout[5], pout[4],
                    pout[3], pout[2], pout[1], pout[0]};

    pixel_sort_asc #(.DATA_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .Pixel_in1 (pin[0]),
        .Pixel_in2 (pin[1]),
        .Pixel_in3 (pin[2]),
        .Pixel_in4 (pin[3]),
        .Pixel_in5 (pin[4]),
        .Pixel_in6 (pin[5]),
        .Pixel_in7 (pin[6]),
        .Pixel_in8 (pin[7]),
        .Pixel_out1(pout[0]),
        .Pixel_out2(pout[1]),
        .Pixel_out3(pout[2]),
        .Pixel_out4(pout[3]),
        .Pixel_out5(pout[4]),
        .Pixel_out6(pout[5]),
        .Pixel_out7(pout[6]),
        .Pixel_out8(pout[7]),
        .valid_out (valid_out)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] p1, input logic [15:0] p2,
                         input logic [15:0] p3, input logic [15:0] p4,
                         input logic [15:0] p5, input logic [15:0] p6,
                         input logic [15:0] p7, input logic [15:0] p8,
                         input logic en);
        pin[0] = p1; pin[1] = p2; pin[2] = p3; pin[3] = p4;
        pin[4] = p5; pin[5] = p6; pin[6] = p7; pin[7] = p8;
        enable = en;
    endtask

    task automatic test_reset();
        drive(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
        #1 reset = 1'b1;
        #2;
        n_tests++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got=%b exp=0", valid_out);
        end
        n_tests++;
        if (got_v !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=0", got_v);
        end
        #7 reset = 1'b0;
    endtask

    task automatic test_basic();
        cyc();
        drive(16'd55, 16'd1037, 16'd345, 16'd345, 16'd45, 16'd234, 16'd456, 16'd344, 1'b1);
        cyc();
        drive(16'd9999, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 1'b0);
        for (int k = 1; k <= LAT + 2; k++) begin
            cyc();
            n_tests++;
            if (valid_out !== (k == LAT)) begin
                n_fail++;
                $display("FAIL basic_valid k=%0d got=%b exp=%b", k, valid_out, (k == LAT));
            end
            n_tests++;
            if (got_v !== ((k < LAT) ? 128'd0 : EXP_A)) begin
                n_fail++;
                $display("FAIL basic_data k=%0d got=%h exp=%h", k, got_v,
                         ((k < LAT) ? 128'd0 : EXP_A));
            end
        end
    endtask

    task automatic test_dup_pair();
        drive(16'd300, 16'd200, 16'd100, 16'd700, 16'd600, 16'd500, 16'd400, 16'd0, 1'b1);
        cyc();
        cyc();
        enable = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            if (k > 1) cyc();
            n_tests++;
            if (valid_out !== (k == LAT || k == LAT + 1)) begin
                n_fail++;
                $display("FAIL dup_valid k=%0d got=%b exp=%b", k, valid_out,
                         (k == LAT || k == LAT + 1));
            end
            if (k >= LAT) begin
                n_tests++;
                if (got_v !== EXP_S) begin
                    n_fail++;
                    $display("FAIL dup_data k=%0d got=%h exp=%h", k, got_v, EXP_S);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 1'b1);
        cyc();
        drive(16'd0, 16'd65535, 16'd0, 16'd65535, 16'd1, 16'd1, 16'd2, 16'd2, 1'b1);
        cyc();
        drive(16'd77, 16'd77, 16'd77, 16'd77, 16'd77, 16'd77, 16'd77, 16'd77, 1'b0);
        for (int k = 1; k <= LAT + 2; k++) begin
            if (k > 1) cyc();
            n_tests++;
            if (valid_out !== (k == LAT || k == LAT + 1)) begin
                n_fail++;
                $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, valid_out,
                         (k == LAT || k == LAT + 1));
            end
            if (k == LAT) begin
                n_tests++;
                if (got_v !== EXP_B1) begin
                    n_fail++;
                    $display("FAIL b2b_first k=%0d got=%h exp=%h", k, got_v, EXP_B1);
                end
            end
            if (k > LAT) begin
                n_tests++;
                if (got_v !== EXP_B2) begin
                    n_fail++;
                    $display("FAIL b2b_second k=%0d got=%h exp=%h", k, got_v, EXP_B2);
                end
            end
        end
    endtask

    task automatic test_idle();
        for (int k = 0; k < 20; k++) begin
            drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
            cyc();
            n_tests++;
            if (valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_valid k=%0d got=%b exp=0", k, valid_out);
            end
            n_tests++;
            if (got_v !== EXP_B2) begin
                n_fail++;
                $display("FAIL idle_hold k=%0d got=%h exp=%h", k, got_v, EXP_B2);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 1'b1);
        cyc();
        enable = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        #1;
        n_tests++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_valid got=%b exp=0", valid_out);
        end
        n_tests++;
        if (got_v !== 128'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got=%h exp=0", got_v);
        end
        cyc();
        cyc();
        reset = 1'b0;
        // First edge after release must accept this set
        drive(16'd4000, 16'd3000, 16'd2000, 16'd1000, 16'd50, 16'd40, 16'd30, 16'd20, 1'b1);
        cyc();
        enable = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            cyc();
            n_tests++;
            if (valid_out !== (k == LAT)) begin
                n_fail++;
                $display("FAIL rstmid_pulse k=%0d got=%b exp=%b", k, valid_out, (k == LAT));
            end
            n_tests++;
            if (got_v !== ((k < LAT) ? 128'd0 : EXP_D)) begin
                n_fail++;
                $display("FAIL rstmid_data k=%0d got=%h exp=%h", k, got_v,
                         ((k < LAT) ? 128'd0 : EXP_D));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dup_pair();
        test_back_to_back();
        test_idle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pixel_sort_asc.md
PIXEL_SORT_ASC -- requirements
Module: pixel_sort_asc

Interface
REQ-001 Parameter DATA_W, default 16: width of each pixel value (unsigned).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  input-valid qualifier; Pixel_in1..8 sampled on a rising clk edge only when enable=1.
REQ-005 Pixel_in1..Pixel_in8  input  DATA_W each  eight unsigned pixels to sort.
REQ-006 Pixel_out1..Pixel_out8  output  DATA_W each  sorted result; Pixel_out1 is smallest, Pixel_out8 largest.
REQ-007 valid_out  output  1  high for exactly one cycle per accepted input set, coincident with its sorted result.

Function
REQ-008 The block SHALL sort the eight inputs ascending by unsigned magnitude; equal values appear as duplicates in adjacent outputs.
REQ-009 Sorting SHALL use Batcher odd-even merge network for 8 elements: 19 compare-exchange elements in 6 layers.
REQ-010 Each compare-exchange SHALL output min on its lower lane and max on its upper lane; equal inputs pass unchanged.
REQ-011 Pipeline: one input register, then three register stages each covering two comparator layers; latency from a sampling edge with enable=1 to valid_out=1 SHALL be 4 clk cycles (edge N samples, edge N+4 presents).
REQ-012 The pipeline SHALL accept a new input set every cycle (throughput 1/cycle); back-to-back enables yield back-to-back valid_out pulses in the same order.
REQ-013 A valid bit SHALL travel alongside the data through every stage; valid_out is the last-stage valid bit.
REQ-014 Pixel_out1..8 SHALL be loaded only when the last-stage valid bit is 1 and SHALL hold their last loaded values otherwise.
REQ-015 Inputs sampled while enable=0 SHALL never affect outputs or valid_out.
REQ-016 No backpressure exists; results are never stalled or dropped.

Reset
REQ-017 While reset=1 every pipeline data register, every valid bit, Pixel_out1..8 and valid_out SHALL be 0, immediately and independent of clk.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight sets; no valid_out pulse for them after reset deasserts.
REQ-019 First sampling edge after reset deassertion SHALL accept input normally if enable=1.

Configuration
REQ-020 Macro PIXEL_SORT_IN_REG_EN: when defined, the input register of REQ-011 is present and latency is 4 cycles.
REQ-021 When PIXEL_SORT_IN_REG_EN is not defined, the inputs feed comparator layer 1 directly, enable feeds the first valid bit, and latency SHALL be 3 cycles; sorting and reset behaviour are otherwise identical.

Structure
REQ-022 Package pixel_sort_pkg SHALL hold DATA_W default, element count (8), comparator layer count (6) and pipeline depth constants.
REQ-023 A combinational sub-module pixel_cmp_swap (inputs a,b; outputs lo,hi) SHALL implement one compare-exchange and be instantiated 19 times.

Verification
REQ-024 Reset 10 ns, enable=1 with inputs 55,1037,345,345,45,234,456,344 -> 4 cycles later valid_out=1 for one cycle per accepted set, outputs 45,55,234,344,345,345,456,1037, held after enable drops.
REQ-025 enable high two consecutive cycles with identical inputs -> two consecutive valid_out pulses, same sorted outputs.
REQ-026 Back-to-back sets 8,7,6,5,4,3,2,1 then 0,65535,0,65535,1,1,2,2 -> 1..8 then 0,0,1,1,2,2,65535,65535 on consecutive cycles.
REQ-027 enable=0 for 20 cycles with changing inputs -> valid_out stays 0, outputs unchanged.
REQ-028 Assert reset 2 cycles after an accepted set -> outputs 0 immediately, no valid_out pulse after release.
REQ-029 Repeat REQ-024 without PIXEL_SORT_IN_REG_EN -> same outputs at 3-cycle latency.
